// File: rtl/as_sc_hs_ro_pkg.sv
// Shared definitions for the ring-oscillator frequency meter.
// Holds the FSM state encoding and the synchronizer settle length.
package as_sc_hs_ro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

    localparam int SETTLE_CYC = 4;
    localparam int SETTLE_W   = $clog2(SETTLE_CYC);

endpackage

// File: rtl/as_sc_hs_ro_sync.sv
// Two-flop synchronizer followed by an edge register; RISE marks a
// synchronized rising edge of D.
// Ports: CLK clock, RST sync active-high reset, D async input,
//        RISE one-cycle pulse per rising edge of D.
module as_sc_hs_ro_sync (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic RISE
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= D;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign RISE = s2 & ~s3;

endmodule

// File: rtl/as_sc_hs_ro_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of
// one selected oscillator over a programmed window of CLK cycles.
// Ports: CLK, RST (sync active-high), RO_IN oscillators, SEL/WINDOW
//        sampled on accepted START, BUSY/DONE status, COUNT/OVF result.
module as_sc_hs_ro_meter #(
    parameter int NUM_RO = 4,
    parameter int SEL_W  = 2,
    parameter int WIN_W  = 16,
    parameter int CNT_W  = 20
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_RO-1:0] RO_IN,
    input  logic [SEL_W-1:0]  SEL,
    input  logic [WIN_W-1:0]  WINDOW,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  COUNT,
    output logic              OVF
);

    import as_sc_hs_ro_pkg::*;

    localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [WIN_W-1:0]    WIN_ONE     = WIN_W'(1);

    state_t              state;
    state_t              state_n;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] settle_n;
    logic [WIN_W-1:0]    win_q;
    logic [WIN_W-1:0]    win_n;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_n;
    logic                ovf_q;
    logic                ovf_n;
    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    sel_n;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    count_n;
    logic                ovf_r;
    logic                ovf_out_n;
    logic                ro_sel;
    logic                rise;

    // Indices with no oscillator behind them read as a constant 0.
    always_comb begin
        ro_sel = 1'b0;
        for (int i = 0; i < NUM_RO; i++) begin
            if (sel_q == SEL_W'(i)) begin
                ro_sel = RO_IN[i];
            end
        end
    end

    as_sc_hs_ro_sync u_sync (
        .CLK  (CLK),
        .RST  (RST),
        .D    (ro_sel),
        .RISE (rise)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            settle_q <= '0;
            win_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            sel_q    <= '0;
            count_r  <= '0;
            ovf_r    <= 1'b0;
        end else begin
            state    <= state_n;
            settle_q <= settle_n;
            win_q    <= win_n;
            cnt_q    <= cnt_n;
            ovf_q    <= ovf_n;
            sel_q    <= sel_n;
            count_r  <= count_n;
            ovf_r    <= ovf_out_n;
        end
    end

    always_comb begin
        state_n   = state;
        settle_n  = settle_q;
        win_n     = win_q;
        cnt_n     = cnt_q;
        ovf_n     = ovf_q;
        sel_n     = sel_q;
        count_n   = count_r;
        ovf_out_n = ovf_r;
        unique case (state)
            ST_IDLE: begin
                if (START) begin
                    state_n  = ST_SETTLE;
                    sel_n    = SEL;
                    win_n    = WINDOW;
                    cnt_n    = '0;
                    ovf_n    = 1'b0;
                    settle_n = '0;
                end
            end
            ST_SETTLE: begin
                // Edges from the previously selected source drain here.
                settle_n = settle_q + 1'b1;
                if (settle_q == SETTLE_LAST) begin
                    state_n = (win_q != '0) ? ST_MEASURE : ST_FINISH;
                end
            end
            ST_MEASURE: begin
                win_n = win_q - WIN_ONE;
                if (rise) begin
                    if (cnt_q == CNT_MAX) begin
                        ovf_n = 1'b1;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                if (win_q == WIN_ONE) begin
                    state_n = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        // Result registers load on entry to FINISH so they line up with DONE.
        if (state != ST_FINISH && state_n == ST_FINISH) begin
            count_n   = cnt_n;
            ovf_out_n = ovf_n;
        end
    end

    assign BUSY  = (state != ST_IDLE);
    assign DONE  = (state == ST_FINISH);
    assign COUNT = count_r;
    assign OVF   = ovf_r;

endmodule

// File: tb/tb_as_sc_hs_ro_meter.sv
// Self-checking bench for as_sc_hs_ro_meter: table vectors, hand-written
// corner sequences and randomized runs against an edge-counting model.
`timescale 1ns/1ps
module tb_as_sc_hs_ro_meter;

    localparam int HM = 32767;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  sel;
    logic [15:0] win;
    logic [3:0]  ro = 4'b0;

    logic        busy_d, done_d, ovf_d;
    logic [19:0] count_d;
    logic        busy_s, done_s, ovf_s;
    logic [3:0]  count_s;
    logic        busy_3, done_3, ovf_3;
    logic [19:0] count_3;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int per[4];
    int ph[4];
    bit lvl[4];
    logic [3:0] hist [0:HM];

    always #5 clk = ~clk;

    as_sc_hs_ro_meter u_dut (
        .CLK(clk), .RST(rst), .RO_IN(ro), .SEL(sel), .WINDOW(win),
        .START(start), .BUSY(busy_d), .DONE(done_d), .COUNT(count_d),
        .OVF(ovf_d)
    );

    as_sc_hs_ro_meter #(.CNT_W(4)) u_sat (
        .CLK(clk), .RST(rst), .RO_IN(ro), .SEL(sel), .WINDOW(win),
        .START(start), .BUSY(busy_s), .DONE(done_s), .COUNT(count_s),
        .OVF(ovf_s)
    );

    as_sc_hs_ro_meter #(.NUM_RO(3), .SEL_W(2)) u_ro3 (
        .CLK(clk), .RST(rst), .RO_IN(ro[2:0]), .SEL(sel), .WINDOW(win),
        .START(start), .BUSY(busy_3), .DONE(done_3), .COUNT(count_3),
        .OVF(ovf_3)
    );

    // Oscillator waveforms; hist[n] is the value driven just after edge n.
    initial begin : drive_ro
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < 4; i++) begin
                if (per[i] == 0) ro[i] = lvl[i];
                else ro[i] = (((cyc + ph[i]) / (per[i] / 2)) % 2) == 1;
            end
            hist[cyc & HM] = ro;
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk_eq(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input longint act,
                           input longint lo, input longint hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Rising edges driven in slots that land inside the MEASURE cycles.
    function automatic int edges(input int s, input int k, input int w);
        int e = 0;
        for (int n = k + 2; n <= k + 1 + w; n++)
            if (hist[n & HM][s] && !hist[(n - 1) & HM][s]) e++;
        return e;
    endfunction

    task automatic wait_idle();
        int g = 0;
        while (busy_d && g < 5000) begin
            tick();
            g++;
        end
        if (busy_d) chk_eq("idle_timeout", 1, 0);
    endtask

    task automatic run(input int s, input int w, output int k);
        int dc;
        wait_idle();
        sel   = s[1:0];
        win   = w[15:0];
        start = 1'b1;
        k     = cyc + 1;
        tick();
        start = 1'b0;
        dc    = -1;
        for (int g = 0; g < w + 50; g++) begin
            if (done_d) begin
                dc = cyc;
                break;
            end
            tick();
        end
        if (dc < 0) begin
            chk_eq("done_timeout", 0, 1);
        end else begin
            chk_eq("done_time", dc + 1 - k, w + 5);
            chk_eq("busy_at_done", busy_d, 1);
            chk_eq("done_sat", done_s, 1);
            chk_eq("done_ro3", done_3, 1);
            tick();
            chk_eq("busy_after", busy_d, 0);
        end
    endtask

    task automatic check_model(input int s, input int k, input int w);
        int e, lo, hi;
        e  = edges(s, k, w);
        lo = (e > 0) ? e - 1 : 0;
        hi = e + 1;
        chk_rng("model_cnt", count_d, lo, hi);
        chk_eq("model_ovf", ovf_d, 0);
        if (lo > 15) begin
            chk_eq("model_sat_cnt", count_s, 15);
            chk_eq("model_sat_ovf", ovf_s, 1);
        end else if (hi < 15) begin
            chk_rng("model_sat_cnt", count_s, lo, hi);
            chk_eq("model_sat_ovf", ovf_s, 0);
        end else begin
            chk_rng("model_sat_cnt", count_s, lo, 15);
        end
        if (s >= 3) chk_eq("model_ro3_cnt", count_3, 0);
        else chk_rng("model_ro3_cnt", count_3, lo, hi);
        chk_eq("model_ro3_ovf", ovf_3, 0);
    endtask

    typedef struct {
        int p0, p1, p2, p3;
        int s, w;
        int lo, hi;
        int slo, shi, sovf;
    } vec_t;

    vec_t tbl[7];

    initial begin : main
        int k, nd, errs, cnt_hold;
        int dq[$];
        rst   = 1'b1;
        start = 1'b0;
        sel   = '0;
        win   = '0;
        for (int i = 0; i < 4; i++) begin
            per[i] = 0;
            ph[i]  = 0;
            lvl[i] = 1'b0;
        end
        lvl[3] = 1'b1;

        tbl[0] = '{0, 0, 10, 0, 2, 1000, 99, 101, 15, 15, 1};
        tbl[1] = '{6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{8, 8, 8, 0, 3, 100, 0, 0, 0, 0, 0};
        tbl[3] = '{6, 12, 0, 0, 0, 120, 19, 21, 15, 15, 1};
        tbl[4] = '{6, 12, 0, 0, 1, 120, 9, 11, 9, 11, 0};
        tbl[5] = '{0, 0, 4, 0, 2, 200, 49, 51, 15, 15, 1};
        tbl[6] = '{0, 0, 4, 0, 2, 20, 4, 6, 4, 6, 0};

        repeat (3) tick();
        chk_eq("rst_busy", busy_d, 0);
        chk_eq("rst_done", done_d, 0);
        chk_eq("rst_count", count_d, 0);
        chk_eq("rst_ovf", ovf_d, 0);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 7; t++) begin
            per[0] = tbl[t].p0;
            per[1] = tbl[t].p1;
            per[2] = tbl[t].p2;
            per[3] = tbl[t].p3;
            run(tbl[t].s, tbl[t].w, k);
            chk_rng("tbl_cnt", count_d, tbl[t].lo, tbl[t].hi);
            chk_rng("tbl_sat_cnt", count_s, tbl[t].slo, tbl[t].shi);
            chk_eq("tbl_sat_ovf", ovf_s, tbl[t].sovf);
            check_model(tbl[t].s, k, tbl[t].w);
        end

        // Reset in the middle of a measurement.
        per[1] = 16;
        wait_idle();
        sel   = 2'd1;
        win   = 16'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (39) tick();
        rst = 1'b1;
        tick();
        chk_eq("mid_rst_busy", busy_d, 0);
        chk_eq("mid_rst_done", done_d, 0);
        chk_eq("mid_rst_count", count_d, 0);
        chk_eq("mid_rst_ovf", ovf_d, 0);
        chk_eq("mid_rst_sat_count", count_s, 0);
        rst = 1'b0;
        nd  = 0;
        for (int g = 0; g < 120; g++) begin
            tick();
            if (done_d) nd++;
        end
        chk_eq("mid_rst_no_done", nd, 0);
        run(1, 100, k);
        check_model(1, k, 100);

        // START pulsed while busy must be dropped.
        per[0] = 4;
        per[2] = 10;
        wait_idle();
        sel   = 2'd2;
        win   = 16'd50;
        start = 1'b1;
        k     = cyc + 1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        sel   = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        nd    = 0;
        for (int g = 0; g < 100; g++) begin
            if (done_d) nd++;
            tick();
        end
        chk_eq("busy_start_dones", nd, 1);
        check_model(2, k, 50);

        // START held high: back-to-back runs with a fixed period.
        per[0] = 6;
        wait_idle();
        sel      = 2'd0;
        win      = 16'd30;
        start    = 1'b1;
        k        = cyc + 1;
        errs     = 0;
        cnt_hold = 0;
        for (int g = 0; g < 200 && dq.size() < 3; g++) begin
            tick();
            if (done_d) begin
                dq.push_back(cyc);
                cnt_hold = count_d;
            end else if (dq.size() > 0 && count_d != cnt_hold) begin
                errs++;
            end
        end
        start = 1'b0;
        chk_eq("held_dones", dq.size(), 3);
        if (dq.size() == 3) begin
            chk_eq("held_first", dq[0] + 1 - k, 35);
            chk_eq("held_gap1", dq[1] - dq[0], 36);
            chk_eq("held_gap2", dq[2] - dq[1], 36);
            chk_rng("held_cnt", count_d, 4, 6);
        end
        chk_eq("held_count_stable", errs, 0);

        // Randomized runs against the edge model.
        for (int r = 0; r < 20; r++) begin
            int s, w;
            for (int i = 0; i < 4; i++) begin
                per[i] = ($urandom_range(0, 3) != 0) ? 2 * $urandom_range(2, 20) : 0;
                ph[i]  = $urandom_range(0, 40);
                lvl[i] = 1'($urandom_range(0, 1));
            end
            s = $urandom_range(0, 3);
            w = $urandom_range(0, 300);
            run(s, w, k);
            check_model(s, k, w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
